// File: rtl/ocp_pkg.sv
// Shared encodings and default widths for the OCP master arbiter slice.
package ocp_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ADDR_W  = 64;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 255;
    localparam int TIMER_W     = 8;

    // OCP MCmd encodings
    typedef enum logic [2:0] {
        MCMD_IDLE = 3'd0,
        MCMD_WR   = 3'd1,
        MCMD_RD   = 3'd2
    } mcmd_e;

    // OCP SResp encodings
    typedef enum logic [1:0] {
        SRESP_NULL = 2'd0,
        SRESP_DVA  = 2'd1,
        SRESP_FAIL = 2'd2,
        SRESP_ERR  = 2'd3
    } sresp_e;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_RESP = 2'd2
    } arb_state_e;

    // True when a slave response code means the read failed
    function automatic logic sresp_is_error(input sresp_e rsp);
        return (rsp == SRESP_FAIL) || (rsp == SRESP_ERR);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, circularly.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               found
);

    logic [NUM_REQ-1:0]   rot_s;
    logic [NUM_REQ-1:0]   rot_gnt_s;
    logic [2*NUM_REQ-1:0] unrot_s;
    logic                 seen_s;

    // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back
    always_comb begin
        rot_s     = NUM_REQ'({req, req} >> ptr);
        rot_gnt_s = '0;
        seen_s    = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            rot_gnt_s[j] = rot_s[j] & ~seen_s;
            seen_s       = seen_s | rot_s[j];
        end
        unrot_s = {{NUM_REQ{1'b0}}, rot_gnt_s} << ptr;
        gnt     = unrot_s[NUM_REQ-1:0] | unrot_s[2*NUM_REQ-1:NUM_REQ];
        found   = seen_s;
    end

endmodule

// File: rtl/ocp_master_arbiter.sv
// Shares one OCP master request path between NUM_REQ requesters, round-robin,
// holding the grant through command acceptance and (for reads) the response.
module ocp_master_arbiter
    import ocp_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      Clk,
    input  logic                      reset,
    input  logic                      EnableClk,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_accept,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_err,
    output logic [ADDR_W-1:0]         address,
    output logic                      read_request,
    output logic                      write_request,
    output logic [DATA_W-1:0]         write_data,
    output logic                      data_valid,
    input  logic                      cmd_accept,
    input  logic                      rsp_valid,
    input  logic                      rsp_err,
    input  logic [DATA_W-1:0]         rsp_data
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_e           state_q, state_d;
    logic [PTR_W-1:0]     grant_q, grant_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [ADDR_W-1:0]    address_q, address_d;
    logic [DATA_W-1:0]    write_data_q, write_data_d;
    logic                 read_request_q, read_request_d;
    logic                 write_request_q, write_request_d;
    logic [NUM_REQ-1:0]   req_accept_q, req_accept_d;
    logic [NUM_REQ-1:0]   rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]    rd_data_q, rd_data_d;
    logic                 rd_err_q, rd_err_d;

    logic [NUM_REQ-1:0]   pick_onehot_s;
    logic                 pick_found_s;
    logic [PTR_W-1:0]     pick_idx_s;
    logic [ADDR_W-1:0]    pick_addr_s;
    logic [DATA_W-1:0]    pick_wdata_s;
    logic                 pick_write_s;
    logic [NUM_REQ-1:0]   grant_onehot_s;
    logic [TIMER_W-1:0]   timer_next_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .gnt   (pick_onehot_s),
        .found (pick_found_s)
    );

    // One-hot mux of the picked requester's index, address, data and direction
    always_comb begin
        pick_idx_s   = '0;
        pick_addr_s  = '0;
        pick_wdata_s = '0;
        pick_write_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_idx_s   = pick_idx_s   | ({PTR_W{pick_onehot_s[i]}} & PTR_W'(i));
            pick_addr_s  = pick_addr_s  | ({ADDR_W{pick_onehot_s[i]}} & req_addr[i*ADDR_W +: ADDR_W]);
            pick_wdata_s = pick_wdata_s | ({DATA_W{pick_onehot_s[i]}} & req_wdata[i*DATA_W +: DATA_W]);
            pick_write_s = pick_write_s | (pick_onehot_s[i] & req_write[i]);
        end
    end

    // Next-state and next-output computation for the sequencer
    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        rr_ptr_d        = rr_ptr_q;
        timer_d         = timer_q;
        address_d       = address_q;
        write_data_d    = write_data_q;
        read_request_d  = read_request_q;
        write_request_d = write_request_q;
        req_accept_d    = '0;
        rd_valid_d      = '0;
        rd_data_d       = rd_data_q;
        rd_err_d        = rd_err_q;
        grant_onehot_s  = NUM_REQ'(1'b1) << grant_q;
        timer_next_s    = timer_q + TIMER_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_d         = ST_ISSUE;
                    grant_d         = pick_idx_s;
                    address_d       = pick_addr_s;
                    write_data_d    = pick_wdata_s;
                    write_request_d = pick_write_s;
                    read_request_d  = ~pick_write_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // Request lines stay put until the master takes the command
                if (cmd_accept) begin
                    req_accept_d    = grant_onehot_s;
                    read_request_d  = 1'b0;
                    write_request_d = 1'b0;
                    rr_ptr_d        = (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + PTR_W'(1);
                    timer_d         = '0;
                    state_d         = read_request_q ? ST_WAIT_RESP : ST_IDLE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT_RESP: begin
                // A response arriving on the timeout cycle takes priority
                if (rsp_valid) begin
                    rd_valid_d = grant_onehot_s;
                    rd_data_d  = rsp_data;
                    rd_err_d   = rsp_err;
                    state_d    = ST_IDLE;
                end else if (timer_next_s == TIMER_W'(TIMEOUT)) begin
                    rd_valid_d = grant_onehot_s;
                    rd_data_d  = '0;
                    rd_err_d   = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    timer_d = timer_next_s;
                end
            end
            default: begin
                state_d         = ST_IDLE;
                read_request_d  = 1'b0;
                write_request_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; everything holds while EnableClk is low
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            grant_q         <= '0;
            rr_ptr_q        <= '0;
            timer_q         <= '0;
            address_q       <= '0;
            write_data_q    <= '0;
            read_request_q  <= 1'b0;
            write_request_q <= 1'b0;
            req_accept_q    <= '0;
            rd_valid_q      <= '0;
            rd_data_q       <= '0;
            rd_err_q        <= 1'b0;
        end else if (EnableClk) begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            rr_ptr_q        <= rr_ptr_d;
            timer_q         <= timer_d;
            address_q       <= address_d;
            write_data_q    <= write_data_d;
            read_request_q  <= read_request_d;
            write_request_q <= write_request_d;
            req_accept_q    <= req_accept_d;
            rd_valid_q      <= rd_valid_d;
            rd_data_q       <= rd_data_d;
            rd_err_q        <= rd_err_d;
        end
    end

    assign address       = address_q;
    assign write_data    = write_data_q;
    assign read_request  = read_request_q;
    assign write_request = write_request_q;
    assign data_valid    = write_request_q;
    assign req_accept    = req_accept_q;
    assign rd_valid      = rd_valid_q;
    assign rd_data       = rd_data_q;
    assign rd_err        = rd_err_q;

endmodule

// File: doc/ocp_master_arbiter.md
Name: ocp_master_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one OCP master request path between NUM_REQ bridge-side requesters (PCIe posted write queue, PCIe read queue, config, DMA).
- Grants one requester at a time, drives the master's request interface, and holds the grant until the command is accepted.
- For reads, it also holds the grant until the response or a timeout, then routes read data back to the granted requester only.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 64, address width
- DATA_W, 8, data width
- TIMEOUT, 255, cycles allowed in WAIT_RESP before an error response (1..255)

Ports:
- Clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- EnableClk  in  1  clock-enable; when low, all state and outputs hold
- req_valid  in  NUM_REQ  per-requester request pending
- req_write  in  NUM_REQ  1=write, 0=read, per requester
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; slice i belongs to requester i
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- req_accept  out  NUM_REQ  one-hot, 1-cycle pulse when requester i's command is accepted downstream
- rd_valid  out  NUM_REQ  one-hot, 1-cycle pulse when read data or error is returned
- rd_data  out  DATA_W  read data, qualified by rd_valid
- rd_err  out  1  read timed out or got an error response, qualified by rd_valid
- address  out  ADDR_W  to master
- read_request  out  1  to master
- write_request  out  1  to master
- write_data  out  DATA_W  to master
- data_valid  out  1  to master; equals write_request
- cmd_accept  in  1  from master; SCmdAccept seen for the current command
- rsp_valid  in  1  from master; read response present
- rsp_err  in  1  from master; response was FAIL or ERR
- rsp_data  in  DATA_W  from master

Behaviour:
- Reset: state=IDLE, rr_ptr=0, grant=0, timer=0.
  - All outputs 0, including address and write_data; no X values.
  - Applies immediately, including mid-transaction; an in-flight command is abandoned with no accept or rd_valid pulse.
- EnableClk=0: no register changes; outputs hold their values.
- IDLE:
  - Pick the first i with req_valid[i], searching circularly from rr_ptr.
  - Register grant=i and state=ISSUE.
  - Drive address, write_data, read_request/write_request from slice i on the next cycle.
  - No req_valid: stay in IDLE.
- ISSUE:
  - Request outputs are held stable until cmd_accept=1.
  - On cmd_accept:
    - Pulse req_accept[grant] and deassert request outputs next cycle.
    - Write: go to IDLE.
    - Read: go to WAIT_RESP with timer=0.
  - rr_ptr=grant+1 modulo NUM_REQ, updated at accept.
  - The granted requester dropping req_valid during ISSUE is ignored; the command completes.
- WAIT_RESP:
  - rsp_valid: rd_valid[grant]=1 for one cycle, rd_data=rsp_data, rd_err=rsp_err, then go to IDLE.
  - Otherwise timer increments; when timer==TIMEOUT and rsp_valid=0: rd_valid[grant]=1, rd_err=1, rd_data=0, then go to IDLE.
  - rsp_valid on the same cycle as the timeout: the response wins.
  - rsp_valid outside WAIT_RESP: ignored.
- Latencies:
  - req_valid to read_request/write_request: 1 cycle minimum.
  - cmd_accept to req_accept: registered, 1 cycle.
  - Back-to-back writes from different requesters: one cycle in IDLE between commands.
- Fairness: every requester holding req_valid continuously is granted within NUM_REQ transactions.
- Output rules: req_accept and rd_valid are never asserted together; at most one bit of each is set.

Decomposition:
- Package ocp_pkg holds:
  - MCmd encodings (IDLE/WR/RD), SResp encodings (NULL/DVA/FAIL/ERR) with distinct values.
  - Arbiter state encoding (IDLE, ISSUE, WAIT_RESP).
  - Default widths.
- Sub-module rr_arbiter: a combinational round-robin pick with inputs req[NUM_REQ] and ptr and outputs a one-hot grant plus a found flag. It is instantiated once.

Test Plan:
- Single write:
  - Stimulus: req_valid=0001, write, addr=0x1000, wdata=0xA5; cmd_accept after 3 cycles.
  - Required: write_request=1 with address=0x1000 and write_data=0xA5, stable for 3 cycles; req_accept=0001 for one cycle; returns to IDLE.
- Read:
  - Stimulus: requester 2 reads 0x20; cmd_accept immediate; rsp_valid with rsp_data=0x3C two cycles later.
  - Required: rd_valid=0100, rd_data=0x3C, rd_err=0.
- Round-robin:
  - Stimulus: req_valid=1111 held, all writes, cmd_accept always 1.
  - Required: grant order 0,1,2,3,0; each req_accept pulses once per 4 commands.
- Timeout:
  - Stimulus: TIMEOUT=8; read accepted; rsp_valid never asserted.
  - Required: rd_valid[grant] and rd_err=1 after 8 WAIT_RESP cycles; next request proceeds normally.
- Reset and enable:
  - Stimulus: assert reset mid-ISSUE with EnableClk=1.
  - Required: outputs 0 immediately with no clock edge; after release, IDLE and rr_ptr=0.
  - Stimulus: EnableClk=0 for 5 cycles during ISSUE.
  - Required: outputs frozen.
